// File: rtl/time_set_pkg.sv
// Shared types, field codes and wrap helpers for the front-panel time-setting controller.
package time_set_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EDIT_HOUR = 3'd1,
    EDIT_MIN  = 3'd2,
    EDIT_AMPM = 3'd3,
    COMMIT    = 3'd4
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_AMPM = 2'd3;

  localparam logic [3:0] HOUR_MIN   = 4'd1;
  localparam logic [3:0] HOUR_MAX   = 4'd12;
  localparam logic [5:0] MINUTE_MAX = 6'd59;

  localparam int BTN_MODE   = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_CANCEL = 2;
  localparam int BTN_COUNT  = 3;

  // Out-of-range hours also fall back to 1 so a corrupt shadow recovers on the next press.
  function automatic logic [3:0] next_hour(input logic [3:0] h);
    return (h >= HOUR_MAX || h < HOUR_MIN) ? HOUR_MIN : h + 4'd1;
  endfunction

  function automatic logic [5:0] next_minute(input logic [5:0] m);
    return (m >= MINUTE_MAX) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      EDIT_HOUR: return FIELD_HOUR;
      EDIT_MIN:  return FIELD_MIN;
      EDIT_AMPM: return FIELD_AMPM;
      default:   return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/time_set_controller_button_debouncer.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle pulse on the debounced rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while a change is pending; any bounce back restarts it.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: rtl/time_set_controller.sv
// Front-panel edit FSM driving the clock core's set interface from a preloaded shadow copy.
// Optional auto-repeat on a held up button: define TIME_SET_AUTO_REPEAT_EN.
module time_set_controller
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int SET_PULSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES   = 1000000,
  parameter int REPEAT_DELAY     = 500000,
  parameter int REPEAT_PERIOD    = 100000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_cancel,
  input  logic [3:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic       cur_am_pm,
  output logic       set_time,
  output logic [3:0] set_hour,
  output logic [5:0] set_minute,
  output logic       set_am_pm,
  output logic       editing,
  output logic [1:0] edit_field
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int PW = (SET_PULSE_CYCLES > 1) ? $clog2(SET_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(SET_PULSE_CYCLES - 1);

  logic [BTN_COUNT-1:0] btn_raw_vec;
  logic [BTN_COUNT-1:0] btn_level_vec;
  logic [BTN_COUNT-1:0] btn_press_vec;

  assign btn_raw_vec = {btn_cancel, btn_up, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_raw  (btn_raw_vec[gi]),
        .btn_level(btn_level_vec[gi]),
        .btn_press(btn_press_vec[gi])
      );
    end
  endgenerate

  logic mode_press, up_press, cancel_press;
  assign mode_press   = btn_press_vec[BTN_MODE];
  assign up_press     = btn_press_vec[BTN_UP];
  assign cancel_press = btn_press_vec[BTN_CANCEL];

  state_t        state_q, state_d;
  logic [3:0]    hour_q, hour_d;
  logic [5:0]    minute_q, minute_d;
  logic          am_pm_q, am_pm_d;
  logic          set_time_q, set_time_d;
  logic          editing_q, editing_d;
  logic [1:0]    edit_field_q, edit_field_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0] inact_q, inact_d;

  logic in_edit;
  logic rpt_fire;
  logic up_evt;

  assign in_edit = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN) || (state_q == EDIT_AMPM);
  assign up_evt  = up_press | rpt_fire;

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_armed_q, rpt_armed_d;

  // First repeat waits the long delay after the press; once armed, the short period applies.
  always_comb begin
    rpt_fire    = 1'b0;
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
    if (in_edit && btn_level_vec[BTN_UP] && !up_press) begin
      if (rpt_cnt_q == (rpt_armed_q ? PERIOD_LAST : DELAY_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + 1'b1;
        rpt_armed_d = rpt_armed_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end

  logic unused_levels;
  assign unused_levels = ^{btn_level_vec[BTN_MODE], btn_level_vec[BTN_CANCEL]};
`else
  assign rpt_fire = 1'b0;

  localparam int unused_repeat = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_levels;
  assign unused_levels = ^btn_level_vec;
`endif

  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    minute_d    = minute_q;
    am_pm_d     = am_pm_q;
    pulse_cnt_d = pulse_cnt_q;
    set_time_d  = 1'b0;
    inact_d     = '0;

    case (state_q)
      IDLE: begin
        if (mode_press) begin
          hour_d   = (cur_hour >= HOUR_MIN && cur_hour <= HOUR_MAX) ? cur_hour : HOUR_MAX;
          minute_d = cur_minute;
          am_pm_d  = cur_am_pm;
          state_d  = EDIT_HOUR;
        end
      end

      EDIT_HOUR, EDIT_MIN, EDIT_AMPM: begin
        if (cancel_press || inact_q == TIMEOUT_LAST) begin
          state_d = IDLE;
        end else begin
          // Up lands on the current field before a simultaneous mode press advances it.
          if (up_evt) begin
            case (state_q)
              EDIT_HOUR: hour_d   = next_hour(hour_q);
              EDIT_MIN:  minute_d = next_minute(minute_q);
              default:   am_pm_d  = ~am_pm_q;
            endcase
          end
          if (mode_press) begin
            case (state_q)
              EDIT_HOUR: state_d = EDIT_MIN;
              EDIT_MIN:  state_d = EDIT_AMPM;
              default: begin
                state_d     = COMMIT;
                set_time_d  = 1'b1;
                pulse_cnt_d = '0;
              end
            endcase
          end
          inact_d = (mode_press || up_evt) ? '0 : inact_q + 1'b1;
        end
      end

      COMMIT: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d = IDLE;
        end else begin
          set_time_d  = 1'b1;
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    editing_d    = (state_d != IDLE);
    edit_field_d = field_of(state_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hour_q       <= HOUR_MAX;
      minute_q     <= '0;
      am_pm_q      <= 1'b0;
      set_time_q   <= 1'b0;
      editing_q    <= 1'b0;
      edit_field_q <= FIELD_NONE;
      pulse_cnt_q  <= '0;
      inact_q      <= '0;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      minute_q     <= minute_d;
      am_pm_q      <= am_pm_d;
      set_time_q   <= set_time_d;
      editing_q    <= editing_d;
      edit_field_q <= edit_field_d;
      pulse_cnt_q  <= pulse_cnt_d;
      inact_q      <= inact_d;
    end
  end

  assign set_time   = set_time_q;
  assign set_hour   = hour_q;
  assign set_minute = minute_q;
  assign set_am_pm  = am_pm_q;
  assign editing    = editing_q;
  assign edit_field = edit_field_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller with short debounce, pulse and timeout settings.
module tb_time_set_controller;

  localparam int DB = 4;
  localparam int SP = 3;
  localparam int TO = 50;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_cancel = 1'b0;
  logic [3:0] cur_hour = 4'd12;
  logic [5:0] cur_minute = 6'd0;
  logic       cur_am_pm = 1'b0;
  logic       set_time;
  logic [3:0] set_hour;
  logic [5:0] set_minute;
  logic       set_am_pm;
  logic       editing;
  logic [1:0] edit_field;

  always #5 clock = ~clock;

  time_set_controller #(
    .DEBOUNCE_CYCLES (DB),
    .SET_PULSE_CYCLES(SP),
    .TIMEOUT_CYCLES  (TO),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_cancel(btn_cancel),
    .cur_hour  (cur_hour),
    .cur_minute(cur_minute),
    .cur_am_pm (cur_am_pm),
    .set_time  (set_time),
    .set_hour  (set_hour),
    .set_minute(set_minute),
    .set_am_pm (set_am_pm),
    .editing   (editing),
    .edit_field(edit_field)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [14:0] exp_q[$];

  // Set-time monitor: pulse length, value stability and the values one cycle before the rise.
  int          st_cycles = 0;
  int          run_len = 0;
  int          last_len = 0;
  logic        pulse_bad = 1'b0;
  logic        prev_st = 1'b0;
  logic [10:0] watch_vals = '0;
  logic [10:0] prev_vals = '0;
  logic [10:0] pre_vals = '0;

  always @(negedge clock) begin
    if (set_time) begin
      st_cycles = st_cycles + 1;
      run_len = run_len + 1;
      if ({set_hour, set_minute, set_am_pm} !== watch_vals) pulse_bad = 1'b1;
      if (!prev_st) pre_vals = prev_vals;
    end else if (run_len != 0) begin
      last_len = run_len;
      run_len = 0;
    end
    prev_st = set_time;
    prev_vals = {set_hour, set_minute, set_am_pm};
  end

  function automatic logic [14:0] mk(input logic [3:0] h, input logic [5:0] m, input logic ap,
                                     input logic [1:0] f, input logic ed, input logic st);
    return {h, m, ap, f, ed, st};
  endfunction

  function automatic logic [14:0] obs();
    return {set_hour, set_minute, set_am_pm, edit_field, editing, set_time};
  endfunction

  task automatic press(input logic [2:0] mask);
    @(negedge clock);
    {btn_cancel, btn_up, btn_mode} = mask;
    repeat (10) @(negedge clock);
    {btn_cancel, btn_up, btn_mode} = 3'b000;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [14:0] got, want;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    exp_q.push_back(mk(4'd12, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    @(negedge clock);
    got = obs();
    want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL reset: got h/m/ap/f/ed/st=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d",
               got[14:11], got[10:5], got[4], got[3:2], got[1], got[0],
               want[14:11], want[10:5], want[4], want[3:2], want[1], want[0]);
    end
    $display("[TB] reset: h/m/ap/f/ed/st=%0d/%0d/%0d/%0d/%0d/%0d", got[14:11], got[10:5], got[4], got[3:2], got[1], got[0]);
  endtask

  task automatic test_bounce_entry();
    logic [14:0] got, want;
    int lat;
    cur_hour = 4'd11; cur_minute = 6'd58; cur_am_pm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      btn_mode = (i % 2 == 0);
      repeat (2) @(negedge clock);
    end
    btn_mode = 1'b1;
    exp_q.push_back(mk(4'd11, 6'd58, 1'b1, 2'd1, 1'b1, 1'b0));
    lat = 0;
    while (lat <= 20 && !editing) begin
      @(negedge clock);
      lat++;
    end
    tests_run++;
    if (lat != 2 + DB + 1) begin
      tests_failed++;
      $display("FAIL press_latency: got %0d cycles expected %0d", lat, 2 + DB + 1);
    end
    got = obs();
    want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL bounce_entry: got h/m/ap/f/ed/st=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d",
               got[14:11], got[10:5], got[4], got[3:2], got[1], got[0],
               want[14:11], want[10:5], want[4], want[3:2], want[1], want[0]);
    end
    $display("[TB] bounce_entry: latency=%0d h/m/ap/f=%0d/%0d/%0d/%0d", lat, got[14:11], got[10:5], got[4], got[3:2]);
    btn_mode = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_field_edits();
    logic [2:0]  masks[9];
    logic [14:0] exps[9];
    logic [14:0] got, want;
    int st_before;
    masks = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b010, 3'b001, 3'b010, 3'b010, 3'b100};
    exps = '{mk(4'd12, 6'd58, 1'b1, 2'd1, 1'b1, 1'b0),
             mk(4'd1,  6'd58, 1'b1, 2'd1, 1'b1, 1'b0),
             mk(4'd1,  6'd58, 1'b1, 2'd2, 1'b1, 1'b0),
             mk(4'd1,  6'd59, 1'b1, 2'd2, 1'b1, 1'b0),
             mk(4'd1,  6'd0,  1'b1, 2'd2, 1'b1, 1'b0),
             mk(4'd1,  6'd0,  1'b1, 2'd3, 1'b1, 1'b0),
             mk(4'd1,  6'd0,  1'b0, 2'd3, 1'b1, 1'b0),
             mk(4'd1,  6'd0,  1'b1, 2'd3, 1'b1, 1'b0),
             mk(4'd1,  6'd0,  1'b1, 2'd0, 1'b0, 1'b0)};
    st_before = st_cycles;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(exps[i]);
      press(masks[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL field_step%0d: got h/m/ap/f/ed/st=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d", i,
                 got[14:11], got[10:5], got[4], got[3:2], got[1], got[0],
                 want[14:11], want[10:5], want[4], want[3:2], want[1], want[0]);
      end
      $display("[TB] field_step%0d: btn=%b h/m/ap/f=%0d/%0d/%0d/%0d", i, masks[i], got[14:11], got[10:5], got[4], got[3:2]);
    end
    tests_run++;
    if (st_cycles != st_before) begin
      tests_failed++;
      $display("FAIL field_no_set: got %0d set_time cycles expected 0", st_cycles - st_before);
    end
  endtask

  task automatic test_commit();
    logic [2:0]  masks[7];
    logic [14:0] exps[7];
    logic [14:0] got, want;
    int st_before;
    cur_hour = 4'd6; cur_minute = 6'd29; cur_am_pm = 1'b1;
    masks = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    exps = '{mk(4'd6, 6'd29, 1'b1, 2'd1, 1'b1, 1'b0),
             mk(4'd7, 6'd29, 1'b1, 2'd1, 1'b1, 1'b0),
             mk(4'd7, 6'd29, 1'b1, 2'd2, 1'b1, 1'b0),
             mk(4'd7, 6'd30, 1'b1, 2'd2, 1'b1, 1'b0),
             mk(4'd7, 6'd30, 1'b1, 2'd3, 1'b1, 1'b0),
             mk(4'd7, 6'd30, 1'b0, 2'd3, 1'b1, 1'b0),
             mk(4'd7, 6'd30, 1'b0, 2'd0, 1'b0, 1'b0)};
    watch_vals = {4'd7, 6'd30, 1'b0};
    pulse_bad = 1'b0;
    st_before = st_cycles;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(exps[i]);
      press(masks[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL commit_step%0d: got h/m/ap/f/ed/st=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d", i,
                 got[14:11], got[10:5], got[4], got[3:2], got[1], got[0],
                 want[14:11], want[10:5], want[4], want[3:2], want[1], want[0]);
      end
      $display("[TB] commit_step%0d: btn=%b h/m/ap/f=%0d/%0d/%0d/%0d", i, masks[i], got[14:11], got[10:5], got[4], got[3:2]);
    end
    tests_run++;
    if (st_cycles - st_before != SP) begin
      tests_failed++;
      $display("FAIL commit_pulse_cycles: got %0d expected %0d", st_cycles - st_before, SP);
    end
    tests_run++;
    if (last_len != SP) begin
      tests_failed++;
      $display("FAIL commit_pulse_len: got %0d expected %0d", last_len, SP);
    end
    tests_run++;
    if (pre_vals !== watch_vals) begin
      tests_failed++;
      $display("FAIL commit_pre_stable: got %h expected %h", pre_vals, watch_vals);
    end
    tests_run++;
    if (pulse_bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL commit_hold_stable: got changed=%0d expected 0", pulse_bad);
    end
    $display("[TB] commit: pulse=%0d cycles pre=%h", last_len, pre_vals);
  endtask

  task automatic test_cancel_with_up();
    logic [2:0]  masks[3];
    logic [14:0] exps[3];
    logic [14:0] got, want;
    int st_before;
    cur_hour = 4'd5; cur_minute = 6'd20; cur_am_pm = 1'b0;
    masks = '{3'b001, 3'b001, 3'b110};
    exps = '{mk(4'd5, 6'd20, 1'b0, 2'd1, 1'b1, 1'b0),
             mk(4'd5, 6'd20, 1'b0, 2'd2, 1'b1, 1'b0),
             mk(4'd5, 6'd20, 1'b0, 2'd0, 1'b0, 1'b0)};
    st_before = st_cycles;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exps[i]);
      press(masks[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL cancel_step%0d: got h/m/ap/f/ed/st=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d", i,
                 got[14:11], got[10:5], got[4], got[3:2], got[1], got[0],
                 want[14:11], want[10:5], want[4], want[3:2], want[1], want[0]);
      end
      $display("[TB] cancel_step%0d: btn=%b h/m/ap/f=%0d/%0d/%0d/%0d", i, masks[i], got[14:11], got[10:5], got[4], got[3:2]);
    end
    tests_run++;
    if (st_cycles != st_before) begin
      tests_failed++;
      $display("FAIL cancel_no_set: got %0d set_time cycles expected 0", st_cycles - st_before);
    end
  endtask

  task automatic test_timeout();
    logic [14:0] got, want;
    int lat;
    int st_before;
    cur_hour = 4'd9; cur_minute = 6'd45; cur_am_pm = 1'b1;
    st_before = st_cycles;
    @(negedge clock);
    btn_mode = 1'b1;
    lat = 0;
    while (lat <= 20 && !editing) begin
      @(negedge clock);
      lat++;
    end
    repeat (TO - 1) @(negedge clock);
    tests_run++;
    if (editing !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_early: got editing=%0d expected 1 after %0d idle cycles", editing, TO - 1);
    end
    exp_q.push_back(mk(4'd9, 6'd45, 1'b1, 2'd0, 1'b0, 1'b0));
    @(negedge clock);
    got = obs();
    want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL timeout_cancel: got h/m/ap/f/ed/st=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d",
               got[14:11], got[10:5], got[4], got[3:2], got[1], got[0],
               want[14:11], want[10:5], want[4], want[3:2], want[1], want[0]);
    end
    tests_run++;
    if (st_cycles != st_before) begin
      tests_failed++;
      $display("FAIL timeout_no_set: got %0d set_time cycles expected 0", st_cycles - st_before);
    end
    $display("[TB] timeout: editing=%0d f=%0d after %0d cycles", got[1], got[3:2], TO);
    btn_mode = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset_in_commit();
    logic [14:0] got, want;
    int waited;
    cur_hour = 4'd2; cur_minute = 6'd5; cur_am_pm = 1'b1;
    press(3'b001);
    press(3'b001);
    press(3'b001);
    @(negedge clock);
    btn_mode = 1'b1;
    waited = 0;
    while (waited <= 20 && !set_time) begin
      @(negedge clock);
      waited++;
    end
    btn_mode = 1'b0;
    tests_run++;
    if (!set_time) begin
      tests_failed++;
      $display("FAIL commit_start: got set_time=0 expected 1 within 20 cycles");
    end
    exp_q.push_back(mk(4'd12, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    got = obs();
    want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL reset_in_commit: got h/m/ap/f/ed/st=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d",
               got[14:11], got[10:5], got[4], got[3:2], got[1], got[0],
               want[14:11], want[10:5], want[4], want[3:2], want[1], want[0]);
    end
    $display("[TB] reset_in_commit: st=%0d h/m/ap=%0d/%0d/%0d", got[0], got[14:11], got[10:5], got[4]);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    exp_q.push_back(mk(4'd12, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    press(3'b010);
    got = obs();
    want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL idle_ignores_up: got h/m/ap/f/ed/st=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d",
               got[14:11], got[10:5], got[4], got[3:2], got[1], got[0],
               want[14:11], want[10:5], want[4], want[3:2], want[1], want[0]);
    end
    $display("[TB] idle_ignores_up: h/m/f=%0d/%0d/%0d", got[14:11], got[10:5], got[3:2]);
  endtask

`ifdef TIME_SET_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    logic [5:0] got, want;
    int waited;
    int incs;
    cur_hour = 4'd4; cur_minute = 6'd58; cur_am_pm = 1'b0;
    press(3'b001);
    press(3'b001);
    @(negedge clock);
    btn_up = 1'b1;
    waited = 0;
    while (waited <= 20 && set_minute != 6'd59) begin
      @(negedge clock);
      waited++;
    end
    for (int k = 1; k <= 26; k++) begin
      incs = 1 + ((k >= RD) ? 1 + (k - RD) / RP : 0);
      exp_q.push_back({9'd0, 6'((58 + incs) % 60)} >> 0);
      @(negedge clock);
      got = set_minute;
      want = 6'(exp_q.pop_front());
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL repeat_k%0d: got minute=%0d expected %0d", k, got, want);
      end
      $display("[TB] repeat_k%0d: minute=%0d", k, got);
    end
    btn_up = 1'b0;
    repeat (10) @(negedge clock);
    press(3'b100);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion before 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bounce_entry();
    test_field_edits();
    test_commit();
    test_cancel_with_up();
    test_timeout();
    test_reset_in_commit();
`ifdef TIME_SET_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
